// File: rtl/rd_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : rd_muldiv_unit
// Brief    : Iterative RV32M multiply/divide unit (radix-2 shift-add multiply,
//            restoring divide) with valid/ready handshakes on both sides.
// Revision : 1.0
// ============================================================================
module rd_muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            kill_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            busy_o
);
    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] c_INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_op;
    logic              r_neg_a;
    logic              r_neg_b;
    logic [XLEN-1:0]   r_opb;
    logic [2*XLEN-1:0] r_acc;
    logic              r_valid;
    logic [XLEN-1:0]   r_result;

    logic              w_is_div, w_sgn_a, w_sgn_b, w_neg_a, w_neg_b;
    logic [XLEN-1:0]   w_abs_a, w_abs_b;
    logic              w_div_zero, w_ovf, w_fast;
    logic [XLEN-1:0]   w_fast_res;
    logic [XLEN:0]     w_mul_sum;
    logic [XLEN:0]     w_shift;
    logic [XLEN+1:0]   w_diff;
    logic [2*XLEN-1:0] w_step;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo, w_rem, w_fix_res;
    logic              w_unused;

    // Operand decode: magnitudes and sign flags captured at accept time.
    always_comb begin
        w_is_div   = op_i[2];
        w_sgn_a    = w_is_div ? !op_i[0] : (op_i[1:0] != 2'b11);
        w_sgn_b    = w_is_div ? !op_i[0] : !op_i[1];
        w_neg_a    = w_sgn_a & rs1_i[XLEN-1];
        w_neg_b    = w_sgn_b & rs2_i[XLEN-1];
        w_abs_a    = w_neg_a ? -rs1_i : rs1_i;
        w_abs_b    = w_neg_b ? -rs2_i : rs2_i;
        w_div_zero = (rs2_i == '0);
        w_ovf      = !op_i[0] && (rs1_i == c_INT_MIN) && (rs2_i == '1);
        w_fast     = w_is_div && (w_div_zero || w_ovf);
        if (w_div_zero) begin
            w_fast_res = op_i[1] ? rs1_i : '1;
        end else begin
            w_fast_res = op_i[1] ? '0 : rs1_i;
        end
    end

    // One iteration: multiply shifts the accumulator right after a
    // conditional add; divide shifts {rem,quo} left with a trial subtract.
    always_comb begin
        w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opb} : '0);
        w_shift   = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
        w_diff    = {1'b0, w_shift} - {2'b00, r_opb};
        if (r_op[2]) begin
            if (w_diff[XLEN+1]) begin
                w_step = {w_shift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
            end else begin
                w_step = {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
            end
        end else begin
            w_step = {w_mul_sum, r_acc[XLEN-1:1]};
        end
        w_unused = &{1'b0, w_diff[XLEN], w_shift[XLEN]};
    end

    always_comb begin
        w_prod = (r_neg_a ^ r_neg_b) ? -r_acc : r_acc;
        w_quo  = (r_neg_a ^ r_neg_b) ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
        w_rem  = r_neg_a ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
        case (r_op)
            3'b000:                 w_fix_res = w_prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_fix_res = w_prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         w_fix_res = w_quo;
            default:                w_fix_res = w_rem;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_op     <= '0;
            r_neg_a  <= 1'b0;
            r_neg_b  <= 1'b0;
            r_opb    <= '0;
            r_acc    <= '0;
            r_valid  <= 1'b0;
            r_result <= '0;
        end else if (kill_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (valid_i) begin
                        r_op    <= op_i;
                        r_neg_a <= w_neg_a;
                        r_neg_b <= w_neg_b;
                        if (w_fast) begin
                            r_result <= w_fast_res;
                            r_valid  <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            r_cnt   <= CNT_W'(XLEN);
                            r_state <= S_CALC;
                            if (w_is_div) begin
                                r_acc <= {{XLEN{1'b0}}, w_abs_a};
                                r_opb <= w_abs_b;
                            end else begin
                                r_acc <= {{XLEN{1'b0}}, w_abs_b};
                                r_opb <= w_abs_a;
                            end
                        end
                    end
                end
                S_CALC: begin
                    if (r_cnt != '0) begin
                        r_acc <= w_step;
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_result <= w_fix_res;
                    r_valid  <= 1'b1;
                    r_state  <= S_DONE;
                end
                default: begin
                    if (ready_i) begin
                        r_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign ready_o  = (r_state == S_IDLE) && !kill_i;
    assign busy_o   = (r_state != S_IDLE);
    assign valid_o  = r_valid;
    assign result_o = r_result;

endmodule
`default_nettype wire

// File: tb/tb_rd_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_rd_muldiv_unit
// Brief    : Scoreboard testbench for rd_muldiv_unit (XLEN=32).
// Revision : 1.0
// ============================================================================
module tb_rd_muldiv_unit;
    localparam int LAT = 34;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [2:0]  op_i = 3'd0;
    logic [31:0] rs1_i = 32'd0;
    logic [31:0] rs2_i = 32'd0;
    logic        kill_i = 1'b0;
    logic        valid_o;
    logic        ready_i = 1'b1;
    logic [31:0] result_o;
    logic        busy_o;

    logic [31:0] sb_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    rd_muldiv_unit #(.XLEN(32)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_ni),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .op_i     (op_i),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .kill_i   (kill_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .result_o (result_o),
        .busy_o   (busy_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sp;
        logic [63:0]        up;
        logic               ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return sp[31:0]; end
            3'd1: begin sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return sp[63:32]; end
            3'd2: begin sp = $signed({{32{a[31]}}, a}) * $signed({32'd0, b}); return sp[63:32]; end
            3'd3: begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        int w = 0;
        while (!ready_o && w < 200) begin @(posedge clk); #1; w++; end
        op_i = op; rs1_i = a; rs2_i = b; valid_i = 1'b1;
        sb_q.push_back(exp);
        @(posedge clk); #1;
        valid_i = 1'b0;
        op_i = 3'($urandom); rs1_i = $urandom; rs2_i = $urandom;
    endtask

    task automatic await_result(output logic [31:0] res, output int lat, output bit to);
        lat = 0; to = 1'b0;
        while (!valid_o && lat < 200) begin @(posedge clk); #1; lat++; end
        if (!valid_o) to = 1'b1;
        res = result_o;
        if (ready_i) begin @(posedge clk); #1; end
    endtask

    task automatic run_table(input string name, input vec_t v[$]);
        logic [31:0] res, e;
        int lat;
        bit to;
        foreach (v[i]) begin
            issue(v[i].op, v[i].a, v[i].b, v[i].exp);
            await_result(res, lat, to);
            e = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hDEAD_BEEF;
            n_vec++;
            if (to || res !== e) begin
                n_err++;
                $display("FAIL %s[%0d] result: got %h expected %h (timeout=%0d)", name, i, res, e, to);
            end
            n_vec++;
            if (lat != v[i].lat) begin
                n_err++;
                $display("FAIL %s[%0d] latency: got %0d expected %0d", name, i, lat, v[i].lat);
            end
        end
    endtask

    task automatic test_reset;
        #12;
        n_vec++;
        if (valid_o !== 1'b0 || result_o !== 32'd0 || busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset outputs: got v=%b r=%h b=%b expected 0/0/0", valid_o, result_o, busy_o);
        end
        @(posedge clk); #1; rst_ni = 1'b1; #1;
        n_vec++;
        if (ready_o !== 1'b1 || busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset ready: got rdy=%b busy=%b expected 1/0", ready_o, busy_o);
        end
    endtask

    task automatic test_mul;
        vec_t v[$];
        v.push_back('{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT});
        v.push_back('{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT});
        v.push_back('{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, LAT});
        v.push_back('{3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, LAT});
        run_table("mul", v);
    endtask

    task automatic test_div;
        vec_t v[$];
        v.push_back('{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, LAT});
        v.push_back('{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, LAT});
        v.push_back('{3'd5, 32'd100, 32'd7, 32'd14, LAT});
        v.push_back('{3'd7, 32'd100, 32'd7, 32'd2, LAT});
        run_table("div", v);
    endtask

    task automatic test_fastpath;
        vec_t v[$];
        v.push_back('{3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 0});
        v.push_back('{3'd6, 32'd5, 32'd0, 32'd5, 0});
        v.push_back('{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0});
        v.push_back('{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0});
        v.push_back('{3'd5, 32'd9, 32'd0, 32'hFFFF_FFFF, 0});
        v.push_back('{3'd7, 32'd9, 32'd0, 32'd9, 0});
        run_table("fast", v);
    endtask

    task automatic test_backpressure;
        logic [31:0] res, e;
        int lat;
        bit to;
        bit bad = 1'b0;
        ready_i = 1'b0;
        issue(3'd5, 32'd100, 32'd7, 32'd14);
        await_result(res, lat, to);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (result_o !== res || valid_o !== 1'b1 || ready_o !== 1'b0) bad = 1'b1;
        end
        n_vec++;
        if (to || bad) begin
            n_err++;
            $display("FAIL backpressure hold: got r=%h v=%b rdy=%b expected %h/1/0", result_o, valid_o, ready_o, res);
        end
        ready_i = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL backpressure release: got v=%b rdy=%b expected 0/1", valid_o, ready_o);
        end
        e = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hDEAD_BEEF;
        n_vec++;
        if (res !== e) begin
            n_err++;
            $display("FAIL backpressure result: got %h expected %h", res, e);
        end
        begin
            vec_t v[$];
            v.push_back('{3'd0, 32'd1234, 32'd5678, 32'd7006652, LAT});
            run_table("after_bp", v);
        end
    endtask

    task automatic test_kill_reset;
        bit seen = 1'b0;
        issue(3'd0, 32'd3, 32'd4, 32'd12);
        repeat (4) begin @(posedge clk); #1; end
        kill_i = 1'b1;
        @(posedge clk); #1;
        kill_i = 1'b0;
        void'(sb_q.pop_back());
        n_vec++;
        if (valid_o !== 1'b0 || busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL kill calc: got v=%b busy=%b expected 0/0", valid_o, busy_o);
        end
        // kill and valid together: request must not be taken
        op_i = 3'd5; rs1_i = 32'd10; rs2_i = 32'd3; valid_i = 1'b1; kill_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0; kill_i = 1'b0;
        n_vec++;
        if (busy_o !== 1'b0 || valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL kill_vs_valid: got busy=%b v=%b expected 0/0", busy_o, valid_o);
        end
        issue(3'd4, 32'd1000, 32'd3, 32'd333);
        repeat (11) begin @(posedge clk); #1; end
        #2 rst_ni = 1'b0;
        #1;
        void'(sb_q.pop_back());
        n_vec++;
        if (valid_o !== 1'b0 || result_o !== 32'd0 || busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset midop: got v=%b r=%h busy=%b expected 0/0/0", valid_o, result_o, busy_o);
        end
        @(posedge clk); #1; rst_ni = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (valid_o) seen = 1'b1;
        end
        n_vec++;
        if (seen) begin
            n_err++;
            $display("FAIL reset no_valid: got valid_o=1 expected 0");
        end
        begin
            vec_t v[$];
            v.push_back('{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT});
            run_table("after_rst", v);
        end
    endtask

    task automatic test_random;
        vec_t v[$];
        logic [2:0]  op;
        logic [31:0] a, b;
        bit fast;
        for (int i = 0; i < 24; i++) begin
            op = 3'($urandom_range(0, 7));
            a = $urandom;
            b = (i % 4 == 1) ? 32'($urandom_range(1, 300)) : $urandom;
            if (i % 6 == 0) b = 32'd0;
            if (i % 8 == 3) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            fast = op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
            v.push_back('{op, a, b, model(op, a, b), fast ? 0 : LAT});
        end
        run_table("rand", v);
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_fastpath();
        test_backpressure();
        test_kill_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
